sound_cue_scheduler: RTL and testbench

- Sits between the per-lane hit judges and the piezo tone generator.
- Collects judgment events from NUM_LANES lanes and arbitrates simultaneous hits.
- Queues the winners in a small FIFO and issues one-cycle tone commands spaced at least MIN_GAP_CYCLES apart. This spacing keeps one cue from cutting off the previous one.
- Provides mute/flush, busy and drop-count status for the game controller.

---
 rtl/sound_cue_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sound_cue_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sound_cue_scheduler.sv
// Judgment-to-tone cue scheduler: arbitrates simultaneous lane hits, queues the winners,
// and issues one-cycle tone commands spaced MIN_GAP_CYCLES apart.
module sound_cue_scheduler #(
    parameter int NUM_LANES      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int MIN_GAP_CYCLES = 3_000_000,
    parameter int GAP_W          = 22
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic [2*NUM_LANES-1:0]             i_Lane_Cmd,
    input  logic                               i_Mute,
    output logic [1:0]                         o_Sound_Cmd,
    output logic                               o_Busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count,
    output logic [7:0]                         o_Drop_Cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = 4;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [GAP_W-1:0]   gap_r, gap_nxt_s;
    logic [1:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic [1:0]         sound_r, sound_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [7:0]         drop_r, drop_nxt_s;

    logic [1:0]         win_code_s;
    logic               win_valid_s;
    logic [SUM_W-1:0]   nz_cnt_s;
    logic               full_s, pop_s, push_s, ovf_drop_s;
    logic [SUM_W-1:0]   drop_sum_s;
    logic [8:0]         drop_tot_s;

    // Arbitration: smallest nonzero code wins (PERFECT < GOOD < MISS); count active lanes.
    always_comb begin
        win_code_s = 2'd0;
        nz_cnt_s   = {SUM_W{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_Lane_Cmd[2*k +: 2] != 2'd0) begin
                nz_cnt_s = nz_cnt_s + SUM_W'(1);
                if ((win_code_s == 2'd0) || (i_Lane_Cmd[2*k +: 2] < win_code_s)) begin
                    win_code_s = i_Lane_Cmd[2*k +: 2];
                end else begin
                    win_code_s = win_code_s;
                end
            end else begin
                nz_cnt_s = nz_cnt_s;
            end
        end
        win_valid_s = (win_code_s != 2'd0);
    end

    // Issue FSM: pop the head from IDLE when unmuted, then hold off for the gap.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        pop_s       = 1'b0;
        sound_nxt_s = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CNT_W{1'b0}}) && !i_Mute) begin
                    pop_s       = 1'b1;
                    sound_nxt_s = mem_r[rd_ptr_r];
                    gap_nxt_s   = GAP_LOAD;
                    state_nxt_s = ST_GAP;
                end else begin
                    gap_nxt_s   = {GAP_W{1'b0}};
                end
            end
            ST_GAP: begin
                if (gap_r <= GAP_W'(1)) begin
                    gap_nxt_s   = {GAP_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s   = gap_r - GAP_W'(1);
                end
            end
            default: begin
                gap_nxt_s   = {GAP_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Queue bookkeeping and drop accounting; mute discards everything silently.
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        push_s     = win_valid_s && !i_Mute && (!full_s || pop_s);
        ovf_drop_s = win_valid_s && !i_Mute && full_s && !pop_s;
        if (i_Mute) begin
            count_nxt_s = {CNT_W{1'b0}};
            drop_sum_s  = {SUM_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
            drop_sum_s = nz_cnt_s - SUM_W'(win_valid_s) + SUM_W'(ovf_drop_s);
        end
        drop_tot_s = {1'b0, drop_r} + {{(9-SUM_W){1'b0}}, drop_sum_s};
        if (drop_tot_s > 9'd255) begin
            drop_nxt_s = 8'd255;
        end else begin
            drop_nxt_s = drop_tot_s[7:0];
        end
        busy_nxt_s = (state_nxt_s == ST_GAP) || (count_nxt_s != {CNT_W{1'b0}});
    end

    // State, queue storage and status registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r  <= ST_IDLE;
            gap_r    <= {GAP_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            sound_r  <= 2'd0;
            busy_r   <= 1'b0;
            drop_r   <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 2'd0;
            end
        end else begin
            state_r <= state_nxt_s;
            gap_r   <= gap_nxt_s;
            count_r <= count_nxt_s;
            sound_r <= sound_nxt_s;
            busy_r  <= busy_nxt_s;
            drop_r  <= drop_nxt_s;
            if (i_Mute) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= win_code_s;
                    wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    assign o_Sound_Cmd  = sound_r;
    assign o_Busy       = busy_r;
    assign o_Fifo_Count = count_r;
    assign o_Drop_Cnt   = drop_r;

endmodule

// File: tb/tb_sound_cue_scheduler.sv
// Self-checking bench for sound_cue_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_sound_cue_scheduler;

    localparam int NL = 4;
    localparam int FD = 4;
    localparam int MG = 8;
    localparam int GW = 22;

    logic          i_Clk = 1'b0;
    logic          i_Rst;
    logic [2*NL-1:0] i_Lane_Cmd;
    logic          i_Mute;
    logic [1:0]    o_Sound_Cmd;
    logic          o_Busy;
    logic [2:0]    o_Fifo_Count;
    logic [7:0]    o_Drop_Cnt;

    sound_cue_scheduler #(
        .NUM_LANES(NL), .FIFO_DEPTH(FD), .MIN_GAP_CYCLES(MG), .GAP_W(GW)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Lane_Cmd(i_Lane_Cmd), .i_Mute(i_Mute),
        .o_Sound_Cmd(o_Sound_Cmd), .o_Busy(o_Busy),
        .o_Fifo_Count(o_Fifo_Count), .o_Drop_Cnt(o_Drop_Cnt)
    );

    always #5 i_Clk = ~i_Clk;

    // reference model state
    logic [1:0] m_q [$];
    int         m_gap;
    logic [1:0] m_sound;
    int         m_drops;

    int n_checks = 0;
    int n_fails  = 0;
    int step;
    int cues [$];
    int cue_vals [$];
    int peak;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [2*NL-1:0] lanes, input logic mute, input logic rst);
        int best;
        int nz;
        int d;
        best = 0;
        nz   = 0;
        d    = 0;
        if (rst) begin
            m_q.delete();
            m_gap   = 0;
            m_sound = 2'd0;
            m_drops = 0;
            return;
        end
        for (int k = 0; k < NL; k++) begin
            if (lanes[2*k +: 2] != 2'd0) nz++;
        end
        for (int p = 1; p <= 3; p++) begin
            for (int k = 0; k < NL; k++) begin
                if (best == 0 && int'(lanes[2*k +: 2]) == p) best = p;
            end
        end
        if (mute) begin
            m_q.delete();
            m_sound = 2'd0;
            if (m_gap > 0) m_gap--;
        end else begin
            if (m_gap == 0 && m_q.size() > 0) begin
                m_sound = m_q.pop_front();
                m_gap   = MG - 1;
            end else begin
                m_sound = 2'd0;
                if (m_gap > 0) m_gap--;
            end
            if (best != 0) begin
                d = nz - 1;
                if (m_q.size() < FD) m_q.push_back(best[1:0]);
                else d++;
            end
            m_drops = (m_drops + d > 255) ? 255 : m_drops + d;
        end
    endtask

    task automatic cycle(input logic [2*NL-1:0] lanes, input logic mute, input logic rst);
        i_Lane_Cmd = lanes;
        i_Mute     = mute;
        i_Rst      = rst;
        @(posedge i_Clk);
        model_edge(lanes, mute, rst);
        @(negedge i_Clk);
        check("sound", 32'(o_Sound_Cmd), 32'(m_sound));
        check("busy", 32'(o_Busy), 32'((m_gap != 0) || (m_q.size() != 0)));
        check("fifo_count", 32'(o_Fifo_Count), 32'(m_q.size()));
        check("drop_cnt", 32'(o_Drop_Cnt), 32'(m_drops));
        if (o_Sound_Cmd != 2'd0) begin
            cues.push_back(step);
            cue_vals.push_back(int'(o_Sound_Cmd));
        end
        if (int'(o_Fifo_Count) > peak) peak = int'(o_Fifo_Count);
        step++;
    endtask

    task automatic do_reset();
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        step = 0;
        peak = 0;
        cues.delete();
        cue_vals.delete();
    endtask

    initial begin
        logic [2*NL-1:0] rl;
        i_Lane_Cmd = '0;
        i_Mute     = 1'b0;
        i_Rst      = 1'b1;
        step       = 0;
        peak       = 0;

        // 1: single cue from lane 2 at edge 10
        do_reset();
        for (int e = 0; e < 26; e++) cycle((e == 10) ? 8'h10 : 8'h00, 1'b0, 1'b0);
        check("t1_cue_count", 32'(cues.size()), 32'd1);
        check("t1_cue_edge", 32'(cues.size() > 0 ? cues[0] : -1), 32'd11);
        check("t1_drops", 32'(o_Drop_Cnt), 32'd0);

        // 2: simultaneous hits, lane 1 (PERFECT) wins
        do_reset();
        for (int e = 0; e < 20; e++) cycle((e == 0) ? 8'h46 : 8'h00, 1'b0, 1'b0);
        check("t2_cue_count", 32'(cues.size()), 32'd1);
        check("t2_cue_val", 32'(cue_vals.size() > 0 ? cue_vals[0] : -1), 32'd1);
        check("t2_drops", 32'(o_Drop_Cnt), 32'd2);

        // 3: backlog and overflow
        do_reset();
        for (int e = 0; e < 42; e++) cycle((e <= 5) ? 8'h03 : 8'h00, 1'b0, 1'b0);
        check("t3_cue_count", 32'(cues.size()), 32'd5);
        for (int i = 0; i < 5 && i < cues.size(); i++) check("t3_cue_edge", 32'(cues[i]), 32'(1 + 8*i));
        check("t3_peak", 32'(peak), 32'd4);
        check("t3_drops", 32'(o_Drop_Cnt), 32'd1);

        // 4: mute flush during a gap, later cue issues normally
        do_reset();
        for (int e = 0; e < 24; e++) begin
            if (e == 0 || (e >= 2 && e <= 4) || e == 12) cycle(8'h08, 1'b0, 1'b0);
            else cycle(8'h00, (e == 5), 1'b0);
            if (e == 5) check("t4_flushed", 32'(o_Fifo_Count), 32'd0);
        end
        check("t4_cue_count", 32'(cues.size()), 32'd2);
        check("t4_cue_edge", 32'(cues.size() > 1 ? cues[1] : -1), 32'd13);

        // 5: reset in the middle of a gap
        do_reset();
        for (int e = 0; e < 12; e++) cycle((e == 0 || e == 6) ? 8'h01 : 8'h00, 1'b0, (e == 4));
        check("t5_cue_count", 32'(cues.size()), 32'd2);
        check("t5_cue_edge", 32'(cues.size() > 1 ? cues[1] : -1), 32'd7);

        // 6: drop counter saturation under full load
        do_reset();
        for (int e = 0; e < 100; e++) cycle(8'hFF, 1'b0, 1'b0);
        check("t6_drops_sat", 32'(o_Drop_Cnt), 32'd255);
        check("t6_cue_count", 32'(cues.size()), 32'd13);
        for (int i = 1; i < cues.size(); i++) check("t6_spacing", 32'(cues[i] - cues[i-1]), 32'd8);

        // random traffic with occasional mute and reset
        do_reset();
        for (int e = 0; e < 3000; e++) begin
            rl = '0;
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 5) == 0) rl[2*k +: 2] = 2'($urandom_range(1, 3));
            end
            cycle(rl, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
